// File: rtl/vram_scanout_if.sv
// Bus bundle for vram_scanout: VRAM port-B read side and the pixel stream side.
interface vram_scanout_if;
  logic [17:0] ADDR_B;
  logic        WE_B;
  logic [7:0]  DATA_B;
  logic [7:0]  Q_B;
  logic [7:0]  PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic        PIX_SOF;
  logic        PIX_EOL;
  logic        PIX_EOF;

  modport master (
    output ADDR_B, WE_B, DATA_B,
    input  Q_B,
    output PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
    input  PIX_READY
  );

  modport slave (
    input  ADDR_B, WE_B, DATA_B,
    output Q_B,
    input  PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
    output PIX_READY
  );
endinterface

// File: rtl/vram_scanout.sv
// Frame scanout from VRAM port B into a 2-entry pixel FIFO with SOF/EOL/EOF markers.
// Double buffering (frame swap at EOF) is enabled by defining VRAM_SCANOUT_DOUBLE_BUF_EN.
module vram_scanout #(
  parameter int unsigned H_ACTIVE    = 256,
  parameter int unsigned V_ACTIVE    = 192,
  parameter int unsigned SECOND_BASE = 49152
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           SWAP_REQ,
  vram_scanout_if.master bus,
  output logic           FRAME_SEL,
  output logic           SWAP_ACK,
  output logic           BUSY
);
  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CW        = $clog2(FRAME_PIX);
  localparam int unsigned XW        = $clog2(H_ACTIVE);
  localparam int unsigned AW        = 18;
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIX - 1);
  localparam logic [XW-1:0] LAST_COL = XW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          frame_sel_q, frame_sel_d;
  logic          pending_q, pending_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  // Markers travel as {sof, eol, eof}
  logic          inf_q, inf_d;
  logic [2:0]    inf_flags_q, inf_flags_d;
  logic          head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic [7:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [2:0]    head_flags_q, head_flags_d, tail_flags_q, tail_flags_d;

  logic [1:0]    load;
  logic          pop, issue, eof_acc, swap_now;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    frame_sel_d  = frame_sel_q;
    ack_d        = 1'b0;
    inf_d        = 1'b0;
    inf_flags_d  = inf_flags_q;
    head_v_d     = head_v_q;
    head_data_d  = head_data_q;
    head_flags_d = head_flags_q;
    tail_v_d     = tail_v_q;
    tail_data_d  = tail_data_q;
    tail_flags_d = tail_flags_q;

    pop     = head_v_q & bus.PIX_READY;
    load    = 2'(head_v_q) + 2'(tail_v_q) + 2'(inf_q);
    issue   = (state_q == FETCH) && ((load <= 2'd1) || ((load == 2'd2) && pop));
    eof_acc = pop & head_flags_q[0];
`ifdef VRAM_SCANOUT_DOUBLE_BUF_EN
    swap_now  = eof_acc & (pending_q | SWAP_REQ);
    pending_d = eof_acc ? 1'b0 : (pending_q | SWAP_REQ);
`else
    swap_now  = eof_acc & pending_q;
    pending_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        col_d = '0;
        if (EN) state_d = FETCH;
      end
      FETCH: begin
        if (issue) begin
          inf_d       = 1'b1;
          inf_flags_d = {cnt_q == '0, col_q == LAST_COL, cnt_q == LAST_PIX};
          if (cnt_q == LAST_PIX) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
            col_d = (col_q == LAST_COL) ? '0 : col_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (eof_acc) begin
          cnt_d   = '0;
          col_d   = '0;
          state_d = EN ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (swap_now) begin
      frame_sel_d = ~frame_sel_q;
      ack_d       = 1'b1;
    end

    // FIFO: shift on pop, then land returning read data in the first free slot
    if (pop) begin
      head_v_d     = tail_v_q;
      head_data_d  = tail_data_q;
      head_flags_d = tail_flags_q;
      tail_v_d     = 1'b0;
    end
    if (inf_q) begin
      if (!head_v_d) begin
        head_v_d     = 1'b1;
        head_data_d  = bus.Q_B;
        head_flags_d = inf_flags_q;
      end else begin
        tail_v_d     = 1'b1;
        tail_data_d  = bus.Q_B;
        tail_flags_d = inf_flags_q;
      end
    end

    addr_d = (frame_sel_d ? AW'(SECOND_BASE) : '0) + AW'(cnt_d);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      frame_sel_q  <= 1'b0;
      pending_q    <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      inf_q        <= 1'b0;
      inf_flags_q  <= '0;
      head_v_q     <= 1'b0;
      head_data_q  <= '0;
      head_flags_q <= '0;
      tail_v_q     <= 1'b0;
      tail_data_q  <= '0;
      tail_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      frame_sel_q  <= frame_sel_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      inf_q        <= inf_d;
      inf_flags_q  <= inf_flags_d;
      head_v_q     <= head_v_d;
      head_data_q  <= head_data_d;
      head_flags_q <= head_flags_d;
      tail_v_q     <= tail_v_d;
      tail_data_q  <= tail_data_d;
      tail_flags_q <= tail_flags_d;
    end
  end

`ifndef VRAM_SCANOUT_DOUBLE_BUF_EN
  logic unused_swap_req;
  assign unused_swap_req = SWAP_REQ;
`endif

  assign bus.ADDR_B    = addr_q;
  assign bus.WE_B      = 1'b0;
  assign bus.DATA_B    = 8'h00;
  assign bus.PIX_DATA  = head_data_q;
  assign bus.PIX_VALID = head_v_q;
  assign bus.PIX_SOF   = head_flags_q[2];
  assign bus.PIX_EOL   = head_flags_q[1];
  assign bus.PIX_EOF   = head_flags_q[0];
  assign FRAME_SEL     = frame_sel_q;
  assign SWAP_ACK      = ack_q;
  assign BUSY          = busy_q;
endmodule

// File: doc/vram_scanout.md
VRAM_SCANOUT -- requirements
Module: vram_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 256, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 192, lines per frame; H_ACTIVE*V_ACTIVE is the frame size in bytes.
REQ-003 SHALL have parameter SECOND_BASE, default 49152, byte base address of frame 1; frame 0 base is 0.
REQ-004 SHALL have ports: CLK in 1, sole clock, rising edge; RST in 1, synchronous active-high reset.
REQ-005 SHALL have ports: EN in 1, scanout enable; SWAP_REQ in 1, buffer-swap request pulse.
REQ-006 SHALL have VRAM port-B side: ADDR_B out 18, read address; WE_B out 1, tied 0; DATA_B out 8, tied 8'h00; Q_B in 8, read data one cycle after ADDR_B.
REQ-007 SHALL have pixel side: PIX_DATA out 8; PIX_VALID out 1; PIX_READY in 1; PIX_SOF out 1, first pixel; PIX_EOL out 1, last pixel of line; PIX_EOF out 1, last pixel of frame.
REQ-008 SHALL have status: FRAME_SEL out 1, frame being scanned; SWAP_ACK out 1, one-cycle swap pulse; BUSY out 1, state not IDLE.

Function
REQ-009 SHALL implement states IDLE, FETCH, DRAIN.
REQ-010 IDLE: EN=1 -> FETCH next cycle; pixel counter = 0.
REQ-011 FETCH: ADDR_B = base(FRAME_SEL) + pixel counter; read issued in a cycle when issue condition holds; counter increments per issue.
REQ-012 Issue condition: FIFO occupancy + in-flight read <= 1, or == 2 with a pop (PIX_VALID & PIX_READY) in the same cycle.
REQ-013 Q_B SHALL be written into a 2-entry FIFO the cycle after issue; PIX_VALID = FIFO non-empty; PIX_DATA/SOF/EOL/EOF from FIFO head.
REQ-014 Latency: FETCH entered cycle N -> first read N, PIX_VALID asserted N+2 when PIX_READY held 1.
REQ-015 Throughput: PIX_READY held 1 -> one pixel per cycle sustained within a frame.
REQ-016 PIX_VALID and head fields SHALL stay stable while PIX_READY=0; no pixel dropped or duplicated.
REQ-017 Markers: SOF at counter 0; EOL when counter mod H_ACTIVE = H_ACTIVE-1; EOF at counter H_ACTIVE*V_ACTIVE-1.
REQ-018 Issue of last pixel -> DRAIN; no further reads issued in DRAIN.
REQ-019 DRAIN: on EOF pixel accepted -> apply pending swap, counter = 0, then FETCH if EN=1 else IDLE.
REQ-020 SWAP_REQ any cycle sets swap-pending; repeated requests before application merge into one swap.
REQ-021 SWAP_REQ in same cycle as EOF acceptance SHALL be applied at that boundary.
REQ-022 Swap applied: FRAME_SEL toggles and SWAP_ACK pulses 1 in the cycle after EOF acceptance; pending cleared.
REQ-023 FRAME_SEL SHALL never change mid-frame.
REQ-024 EN deasserted mid-frame: current frame completes; IDLE after EOF acceptance.

Reset
REQ-025 RST=1 SHALL force: state IDLE, counter 0, FIFO empty, in-flight cleared, pending cleared, FRAME_SEL 0.
REQ-026 Outputs during/after reset: PIX_VALID 0, SOF/EOL/EOF 0, PIX_DATA 8'h00, SWAP_ACK 0, BUSY 0, ADDR_B 0, WE_B 0.
REQ-027 RST mid-frame SHALL discard in-flight and buffered pixels; next frame starts at pixel 0 of frame 0.

Configuration
REQ-028 Macro VRAM_SCANOUT_DOUBLE_BUF_EN defined: double buffering per REQ-019..023.
REQ-029 Macro undefined: FRAME_SEL held 0, SWAP_REQ ignored, SWAP_ACK held 0, base always 0.

Verification
REQ-030 Reset, EN=1, PIX_READY=1, VRAM preloaded with byte=addr[7:0] -> PIX_VALID at cycle 2 after FETCH entry; 49152 pixels in order; SOF on 0, EOL every 256th, EOF on 49151.
REQ-031 PIX_READY random 50% -> output sequence identical to REQ-030, data held stable on stall cycles.
REQ-032 SWAP_REQ pulsed at pixel 1000 -> frame 0 completes; FRAME_SEL=1 and SWAP_ACK=1 cycle after EOF; next frame ADDR_B starts at 49152.
REQ-033 SWAP_REQ coincident with EOF acceptance, and three SWAP_REQs in one frame -> exactly one toggle each case.
REQ-034 RST at pixel 20000 with FIFO full -> PIX_VALID 0 next cycle, FRAME_SEL 0, restart at address 0, no stale pixel.
REQ-035 EN dropped at pixel 100 -> frame completes to EOF, BUSY 0 afterward, no reads issued; macro undefined build -> SWAP_REQ has no effect.
